// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer for the MIPS core: tick-paced FSM with counted memory waits.
// Optional single-step HOLD state is built when SEQ_SINGLE_STEP_EN is defined.
module multicycle_sequencer #(
    parameter int TICK_DIV    = 1,
    parameter int MEM_LATENCY = 3,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             top_en,
    input  logic [3:0]       path_index,
    input  logic             mem_ready,
    input  logic             step_mode,
    input  logic             step,
    output logic             mem_en,
    output logic             mem_ren,
    output logic             mem_wen,
    output logic [1:0]       addr_sel,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_redirect,
    output logic             decoder_en,
    output logic             reg_en,
    output logic             reg_write,
    output logic             alu_en,
    output logic             jump_en,
    output logic             branch_en,
    output logic [7:0]       stage,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WAIT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LATENCY);

    localparam logic [7:0] ST_IF  = 8'h01;
    localparam logic [7:0] ST_REG = 8'h02;
    localparam logic [7:0] ST_EX  = 8'h04;
    localparam logic [7:0] ST_MEM = 8'h08;
    localparam logic [7:0] ST_WB  = 8'h10;
    localparam logic [7:0] ST_JU  = 8'h20;
    localparam logic [7:0] ST_BR  = 8'h40;
    localparam logic [7:0] ST_SK  = 8'h80;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        FWAIT    = 4'd2,
        DECODE   = 4'd3,
        DISPATCH = 4'd4,
        REGFILE  = 4'd5,
        EXECUTE  = 4'd6,
        MEMORY   = 4'd7,
        MWAIT    = 4'd8,
        REGWRITE = 4'd9,
        JUMP     = 4'd10,
        BRANCH   = 4'd11,
        SINK     = 4'd12
`ifdef SEQ_SINGLE_STEP_EN
        , HOLD   = 4'd13
`endif
    } state_t;

    state_t              state_r, next_state_s, retire_dest_s;
    logic [TICK_W-1:0]   tick_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_r, wait_inc_s;
    logic [3:0]          path_r, path_s;
    logic                redirect_r, advance_s, wait_done_s, retire_s, illegal_set_s;
    logic                mem_en_s, mem_ren_s, mem_wen_s, ir_load_s, pc_inc_s, pc_redirect_s;
    logic                decoder_en_s, reg_en_s, reg_write_s, alu_en_s, jump_en_s, branch_en_s;
    logic [1:0]          addr_sel_s;
    logic [7:0]          stage_s;

`ifdef SEQ_SINGLE_STEP_EN
    logic step_seen_r, step_seen_s;
    assign retire_dest_s = step_mode ? HOLD : FETCH;
    assign step_seen_s   = step_seen_r | step;

    // Remember a step pulse seen between ticks while parked in HOLD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_seen_r <= 1'b0;
        end else begin
            step_seen_r <= (state_r == HOLD) && !advance_s && step_seen_s;
        end
    end
`else
    logic unused_s;
    assign retire_dest_s = FETCH;
    assign unused_s      = ^{step_mode, step};
`endif

    // Free-running divider; ticks keep counting even while top_en is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    assign advance_s   = (tick_cnt_r == TICK_LAST) && top_en;
    assign wait_inc_s  = (wait_cnt_r == WAIT_LAST) ? wait_cnt_r : wait_cnt_r + WAIT_W'(1);
    assign wait_done_s = (wait_inc_s == WAIT_LAST) && mem_ready;
    assign path_s      = (state_r == DISPATCH) ? path_index : path_r;

    // Next-state selection, retire detection and illegal-class detection.
    always_comb begin
        next_state_s  = state_r;
        retire_s      = 1'b0;
        illegal_set_s = 1'b0;
        case (state_r)
            IDLE:     next_state_s = FETCH;
            FETCH:    next_state_s = FWAIT;
            FWAIT: begin
                if (wait_done_s) begin
                    next_state_s = DECODE;
                end else begin
                    next_state_s = FWAIT;
                end
            end
            DECODE:   next_state_s = DISPATCH;
            DISPATCH: begin
                case (path_s)
                    4'd0, 4'd6:                         next_state_s = REGWRITE;
                    4'd5:                               next_state_s = JUMP;
                    4'd9:                               next_state_s = SINK;
                    4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8: next_state_s = REGFILE;
                    default: begin
                        next_state_s  = SINK;
                        illegal_set_s = 1'b1;
                    end
                endcase
            end
            REGFILE: begin
                if (path_s == 4'd8) begin
                    next_state_s = JUMP;
                end else begin
                    next_state_s = EXECUTE;
                end
            end
            EXECUTE: begin
                case (path_s)
                    4'd1:       next_state_s = REGWRITE;
                    4'd2, 4'd3: next_state_s = MEMORY;
                    4'd4:       next_state_s = BRANCH;
                    4'd7: begin
                        next_state_s = retire_dest_s;
                        retire_s     = 1'b1;
                    end
                    default: begin
                        next_state_s  = SINK;
                        illegal_set_s = 1'b1;
                    end
                endcase
            end
            MEMORY:   next_state_s = MWAIT;
            MWAIT: begin
                if (!wait_done_s) begin
                    next_state_s = MWAIT;
                end else if (path_s == 4'd2) begin
                    next_state_s = REGWRITE;
                end else begin
                    next_state_s = retire_dest_s;
                    retire_s     = 1'b1;
                end
            end
            REGWRITE: begin
                if (path_s == 4'd6) begin
                    next_state_s = JUMP;
                end else begin
                    next_state_s = retire_dest_s;
                    retire_s     = 1'b1;
                end
            end
            JUMP, BRANCH: begin
                next_state_s = retire_dest_s;
                retire_s     = 1'b1;
            end
            SINK:     next_state_s = SINK;
`ifdef SEQ_SINGLE_STEP_EN
            HOLD: begin
                if (step_seen_s) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = HOLD;
                end
            end
`endif
            default:  next_state_s = IDLE;
        endcase
    end

    // Output values for the state being entered; FWAIT keeps the fetch address select.
    always_comb begin
        {mem_en_s, mem_ren_s, mem_wen_s} = 3'b000;
        addr_sel_s = 2'd0;
        {ir_load_s, pc_inc_s, pc_redirect_s} = 3'b000;
        {decoder_en_s, reg_en_s, reg_write_s, alu_en_s, jump_en_s, branch_en_s} = 6'b000000;
        stage_s = 8'h00;
        case (next_state_s)
            FETCH: begin
                {mem_en_s, mem_ren_s} = 2'b11;
                addr_sel_s = redirect_r ? 2'd2 : 2'd0;
                stage_s    = ST_IF;
            end
            FWAIT: begin
                {mem_en_s, mem_ren_s} = 2'b11;
                addr_sel_s = addr_sel;
                stage_s    = ST_IF;
            end
            DECODE: begin
                {ir_load_s, pc_inc_s, decoder_en_s} = 3'b111;
                stage_s = ST_REG;
            end
            DISPATCH: stage_s = ST_REG;
            REGFILE: begin
                reg_en_s = 1'b1;
                stage_s  = ST_REG;
            end
            EXECUTE: begin
                alu_en_s = 1'b1;
                stage_s  = ST_EX;
            end
            MEMORY, MWAIT: begin
                mem_en_s   = 1'b1;
                mem_ren_s  = (path_s == 4'd2);
                mem_wen_s  = (path_s == 4'd3);
                addr_sel_s = 2'd1;
                stage_s    = ST_MEM;
            end
            REGWRITE: begin
                {reg_en_s, reg_write_s} = 2'b11;
                stage_s = ST_WB;
            end
            JUMP: begin
                {jump_en_s, pc_redirect_s} = 2'b11;
                stage_s = ST_JU;
            end
            BRANCH: begin
                {branch_en_s, pc_redirect_s} = 2'b11;
                stage_s = ST_BR;
            end
            SINK:    stage_s = ST_SK;
            default: stage_s = 8'h00;
        endcase
    end

    // Sequencer state, wait counter, redirect flag and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            wait_cnt_r  <= {WAIT_W{1'b0}};
            path_r      <= 4'd0;
            redirect_r  <= 1'b0;
            {mem_en, mem_ren, mem_wen} <= 3'b000;
            addr_sel    <= 2'd0;
            {ir_load, pc_inc, pc_redirect} <= 3'b000;
            {decoder_en, reg_en, reg_write, alu_en, jump_en, branch_en} <= 6'b000000;
            stage       <= 8'h00;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            retired     <= {CNT_W{1'b0}};
        end else if (advance_s) begin
            state_r <= next_state_s;
            if ((state_r == FETCH) || (state_r == MEMORY)) begin
                wait_cnt_r <= {WAIT_W{1'b0}};
            end else if ((state_r == FWAIT) || (state_r == MWAIT)) begin
                wait_cnt_r <= wait_inc_s;
            end
            if (state_r == DISPATCH) begin
                path_r <= path_index;
            end
            if ((next_state_s == JUMP) || (next_state_s == BRANCH)) begin
                redirect_r <= 1'b1;
            end else if (state_r == FETCH) begin
                redirect_r <= 1'b0;
            end
            {mem_en, mem_ren, mem_wen} <= {mem_en_s, mem_ren_s, mem_wen_s};
            addr_sel    <= addr_sel_s;
            {ir_load, pc_inc, pc_redirect} <= {ir_load_s, pc_inc_s, pc_redirect_s};
            {decoder_en, reg_en, reg_write, alu_en, jump_en, branch_en} <=
                {decoder_en_s, reg_en_s, reg_write_s, alu_en_s, jump_en_s, branch_en_s};
            stage       <= stage_s;
            halted      <= (next_state_s == SINK);
            illegal     <= illegal | illegal_set_s;
            if (retire_s) begin
                retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: TICK_DIV=1 instruction walk plus a TICK_DIV=4 freeze case.
module tb_multicycle_sequencer;
    localparam logic [7:0] ST_0   = 8'h00;
    localparam logic [7:0] ST_IF  = 8'h01;
    localparam logic [7:0] ST_REG = 8'h02;
    localparam logic [7:0] ST_EX  = 8'h04;
    localparam logic [7:0] ST_MEM = 8'h08;
    localparam logic [7:0] ST_WB  = 8'h10;
    localparam logic [7:0] ST_JU  = 8'h20;
    localparam logic [7:0] ST_BR  = 8'h40;
    localparam logic [7:0] ST_SK  = 8'h80;

    // {mem_en,mem_ren,mem_wen}, addr_sel, {ir_load,pc_inc,pc_redirect}, {dec,reg_en,reg_wr,alu,jump,branch}
    localparam logic [13:0] C_NONE = 14'd0;
    localparam logic [13:0] C_F0   = {3'b110, 2'd0, 3'b000, 6'b000000};
    localparam logic [13:0] C_F2   = {3'b110, 2'd2, 3'b000, 6'b000000};
    localparam logic [13:0] C_DEC  = {3'b000, 2'd0, 3'b110, 6'b100000};
    localparam logic [13:0] C_RF   = {3'b000, 2'd0, 3'b000, 6'b010000};
    localparam logic [13:0] C_EX   = {3'b000, 2'd0, 3'b000, 6'b000100};
    localparam logic [13:0] C_MLD  = {3'b110, 2'd1, 3'b000, 6'b000000};
    localparam logic [13:0] C_MST  = {3'b101, 2'd1, 3'b000, 6'b000000};
    localparam logic [13:0] C_RW   = {3'b000, 2'd0, 3'b000, 6'b011000};
    localparam logic [13:0] C_JMP  = {3'b000, 2'd0, 3'b001, 6'b000010};
    localparam logic [13:0] C_BR   = {3'b000, 2'd0, 3'b001, 6'b000001};

    logic clk = 1'b0;
    logic reset, top_en, mem_ready, top_en4, mem_ready4, step_mode, step;
    logic [3:0] path_index, path_index4;

    logic mem_en, mem_ren, mem_wen, ir_load, pc_inc, pc_redirect, decoder_en;
    logic reg_en, reg_write, alu_en, jump_en, branch_en, halted, illegal;
    logic [1:0] addr_sel;
    logic [7:0] stage;
    logic [31:0] retired;

    logic mem_en4, mem_ren4, mem_wen4, ir_load4, pc_inc4, pc_redirect4, decoder_en4;
    logic reg_en4, reg_write4, alu_en4, jump_en4, branch_en4, halted4, illegal4;
    logic [1:0] addr_sel4;
    logic [7:0] stage4;
    logic [31:0] retired4;

    logic [13:0] ctrl, ctrl4;
    int total = 0;
    int bad = 0;

    assign ctrl  = {mem_en, mem_ren, mem_wen, addr_sel, ir_load, pc_inc, pc_redirect,
                    decoder_en, reg_en, reg_write, alu_en, jump_en, branch_en};
    assign ctrl4 = {mem_en4, mem_ren4, mem_wen4, addr_sel4, ir_load4, pc_inc4, pc_redirect4,
                    decoder_en4, reg_en4, reg_write4, alu_en4, jump_en4, branch_en4};

    always #5 clk = ~clk;

    multicycle_sequencer #(.TICK_DIV(1), .MEM_LATENCY(3), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .top_en(top_en), .path_index(path_index),
        .mem_ready(mem_ready), .step_mode(step_mode), .step(step),
        .mem_en(mem_en), .mem_ren(mem_ren), .mem_wen(mem_wen), .addr_sel(addr_sel),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_redirect(pc_redirect),
        .decoder_en(decoder_en), .reg_en(reg_en), .reg_write(reg_write), .alu_en(alu_en),
        .jump_en(jump_en), .branch_en(branch_en), .stage(stage), .halted(halted),
        .illegal(illegal), .retired(retired)
    );

    multicycle_sequencer #(.TICK_DIV(4), .MEM_LATENCY(3), .CNT_W(32)) dut4 (
        .clk(clk), .reset(reset), .top_en(top_en4), .path_index(path_index4),
        .mem_ready(mem_ready4), .step_mode(step_mode), .step(step),
        .mem_en(mem_en4), .mem_ren(mem_ren4), .mem_wen(mem_wen4), .addr_sel(addr_sel4),
        .ir_load(ir_load4), .pc_inc(pc_inc4), .pc_redirect(pc_redirect4),
        .decoder_en(decoder_en4), .reg_en(reg_en4), .reg_write(reg_write4), .alu_en(alu_en4),
        .jump_en(jump_en4), .branch_en(branch_en4), .stage(stage4), .halted(halted4),
        .illegal(illegal4), .retired(retired4)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [7:0] stg, input logic [13:0] ctl);
        @(posedge clk);
        #1;
        check_val({tag, " stage"}, 32'(stage), 32'(stg));
        check_val({tag, " ctrl"}, 32'(ctrl), 32'(ctl));
    endtask

    // FWAIT x3, DECODE, DISPATCH with mem_ready high
    task automatic front(input string tag, input logic [13:0] fw_ctl);
        for (int i = 0; i < 3; i++) cyc({tag, " fwait"}, ST_IF, fw_ctl);
        cyc({tag, " decode"}, ST_REG, C_DEC);
        cyc({tag, " dispatch"}, ST_REG, C_NONE);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  exp_stg;
        logic [13:0] exp_ctl;
        reset = 1'b0; top_en = 1'b1; mem_ready = 1'b1; path_index = 4'd1;
        top_en4 = 1'b0; mem_ready4 = 1'b1; path_index4 = 4'd1;
        step_mode = 1'b0; step = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset stage", 32'(stage), 32'd0);
        check_val("reset ctrl", 32'(ctrl), 32'd0);
        check_val("reset retired", retired, 32'd0);
        check_val("reset halted", 32'(halted), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // path 1: ALU op with writeback
        cyc("p1 fetch", ST_IF, C_F0);
        check_val("p1 retired", retired, 32'd0);
        front("p1", C_F0);
        cyc("p1 regfile", ST_REG, C_RF);
        cyc("p1 execute", ST_EX, C_EX);
        cyc("p1 regwrite", ST_WB, C_RW);
        path_index = 4'd2;
        cyc("ld fetch", ST_IF, C_F0);
        check_val("p1 retired after", retired, 32'd1);

        // load with mem_ready held low for 5 extra ticks
        front("ld", C_F0);
        cyc("ld regfile", ST_REG, C_RF);
        cyc("ld execute", ST_EX, C_EX);
        cyc("ld memory", ST_MEM, C_MLD);
        mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) cyc("ld mwait", ST_MEM, C_MLD);
        mem_ready = 1'b1;
        cyc("ld regwrite", ST_WB, C_RW);
        path_index = 4'd3;
        cyc("st fetch", ST_IF, C_F0);
        check_val("ld retired", retired, 32'd2);

        // store
        front("st", C_F0);
        cyc("st regfile", ST_REG, C_RF);
        cyc("st execute", ST_EX, C_EX);
        cyc("st memory", ST_MEM, C_MST);
        for (int i = 0; i < 3; i++) cyc("st mwait", ST_MEM, C_MST);
        path_index = 4'd6;
        cyc("jal fetch", ST_IF, C_F0);
        check_val("st retired", retired, 32'd3);

        // jal: writeback then jump, single retire
        front("jal", C_F0);
        cyc("jal regwrite", ST_WB, C_RW);
        check_val("jal retired mid", retired, 32'd3);
        cyc("jal jump", ST_JU, C_JMP);
        path_index = 4'd7;
        cyc("p7 fetch", ST_IF, C_F2);
        check_val("jal retired", retired, 32'd4);

        // path 7 retires straight from EXECUTE; redirect flag must be consumed
        front("p7", C_F2);
        cyc("p7 regfile", ST_REG, C_RF);
        cyc("p7 execute", ST_EX, C_EX);
        path_index = 4'd4;
        cyc("br fetch", ST_IF, C_F0);
        check_val("p7 retired", retired, 32'd5);

        // branch
        front("br", C_F0);
        cyc("br regfile", ST_REG, C_RF);
        cyc("br execute", ST_EX, C_EX);
        cyc("br branch", ST_BR, C_BR);
        path_index = 4'd12;
        cyc("ill fetch", ST_IF, C_F2);
        check_val("br retired", retired, 32'd6);

        // illegal class lands in SINK and stays there
        front("ill", C_F2);
        cyc("ill sink", ST_SK, C_NONE);
        check_val("ill illegal", 32'(illegal), 32'd1);
        check_val("ill halted", 32'(halted), 32'd1);
        repeat (100) @(posedge clk);
        #1;
        check_val("sink hold stage", 32'(stage), 32'(ST_SK));
        check_val("sink hold retired", retired, 32'd6);
        check_val("sink hold halted", 32'(halted), 32'd1);

        // asynchronous reset mid-cycle clears everything immediately
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_val("async rst stage", 32'(stage), 32'd0);
        check_val("async rst ctrl", 32'(ctrl), 32'd0);
        check_val("async rst flags", {30'd0, halted, illegal}, 32'd0);
        check_val("async rst retired", retired, 32'd0);

        // TICK_DIV=4: advance every 4th clk, wait count frozen while top_en is low
        top_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        top_en4 = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            @(posedge clk);
            #1;
            if (c == 13) top_en4 = 1'b0;
            if (c == 23) top_en4 = 1'b1;
            exp_stg = (c < 4) ? ST_0 : ((c < 28) ? ST_IF : ST_REG);
            exp_ctl = (c < 4) ? C_NONE : ((c < 28) ? C_F0 : C_DEC);
            check_val($sformatf("div4 stage c%0d", c), 32'(stage4), 32'(exp_stg));
            check_val($sformatf("div4 ctrl c%0d", c), 32'(ctrl4), 32'(exp_ctl));
        end
        check_val("div4 retired", retired4, 32'd0);
        check_val("div1 idle while off", 32'(stage), 32'(ST_0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Parametrised multicycle control sequencer for the MIPS core. It replaces fixed read-delay states with counted wait states and a memory-ready handshake.
- It takes the decoded path class from decoder_control and drives enable, strobe and PC-update controls to the regfile, ALU, memory, branch and jump units.
- An internal tick divider paces the state machine, so board-speed stepping needs no derived clock.

Parameters:
- TICK_DIV, 1, FSM advances once every TICK_DIV clk cycles (1 = every cycle); minimum 1.
- MEM_LATENCY, 3, wait cycles (in ticks) after a memory request before mem_ready is sampled; minimum 1.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- top_en  in  1  run enable; when low the FSM holds its current state (ticks still counted)
- path_index  in  4  decoded instruction class, valid from DECODE+1 tick
- mem_ready  in  1  memory data valid / write accepted
- step_mode  in  1  single-step select (used only with the optional feature)
- step  in  1  single-step pulse (used only with the optional feature)
- mem_en, mem_ren, mem_wen  out  1 each  memory strobes
- addr_sel  out  2  mem address mux select: 0 = pc, 1 = alu_result, 2 = redirected pc
- ir_load  out  1  one-tick instruction register load
- pc_inc  out  1  one-tick pc+1
- pc_redirect  out  1  one-tick pc load from the jump/branch target
- decoder_en, reg_en, reg_write, alu_en, jump_en, branch_en  out  1 each  unit enables
- stage  out  8  one-hot debug LEDs {SK,BR,JU,WB,MEM,EX,REG,IF}
- halted  out  1  in SINK
- illegal  out  1  sticky; set when an unknown path_index is reached
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, active-low):
  - state = IDLE; all outputs 0; tick counter 0; wait counter 0.
- Tick generation:
  - tick is high for one clk every TICK_DIV cycles.
  - State changes and output updates occur only on clk edges where tick=1 and top_en=1.
- States and transitions:
  - IDLE -> FETCH.
  - FETCH: mem_en=1, mem_ren=1; addr_sel=2 if the previous instruction redirected, else 0; clear wait counter. -> FWAIT.
  - FWAIT: count ticks. When the count reaches MEM_LATENCY and mem_ready=1: ir_load=1 for one tick, -> DECODE. If mem_ready=0 at that point, stay in FWAIT with the counter saturated.
  - DECODE: decoder_en=1, pc_inc=1 (one tick), mem strobes 0. -> DISPATCH.
  - DISPATCH:
    - path 0 or 6 -> REGWRITE
    - path 5 -> JUMP
    - path 9 -> SINK
    - path 1, 2, 3, 4, 7, 8 -> REGFILE
    - path 10-15 -> SINK with illegal=1
  - REGFILE: reg_en=1. Path 8 -> JUMP; otherwise -> EXECUTE.
  - EXECUTE: alu_en=1.
    - path 1 -> REGWRITE
    - path 2 or 3 -> MEMORY
    - path 4 -> BRANCH
    - path 7 -> FETCH (retire)
  - MEMORY: addr_sel=1, mem_en=1; mem_ren=1 for path 2, mem_wen=1 for path 3. -> MWAIT.
  - MWAIT: same latency/handshake rule as FWAIT.
    - Load: -> REGWRITE.
    - Store: mem_wen drops the tick after acceptance, -> FETCH (retire).
  - REGWRITE: reg_en=1, reg_write=1 for exactly one tick. Path 6 -> JUMP; otherwise -> FETCH (retire).
  - JUMP: jump_en=1, pc_redirect=1, set redirect flag. -> FETCH (retire).
  - BRANCH: branch_en=1, pc_redirect=1, set redirect flag. -> FETCH (retire).
  - SINK: absorbing; halted=1. Only reset exits.
- Retire:
  - retired increments by 1 on every transition into FETCH except from IDLE; wraps modulo 2^CNT_W.
- Redirect flag: cleared in FETCH after it has been used.
- stage: exactly one bit set, matching the current phase; all zero in IDLE.
- top_en low mid-wait: the wait counter freezes and resumes on re-enable. mem_ready pulses arriving while top_en is low are ignored.
- Reset mid-operation: immediate return to IDLE with all strobes low; no partial write is held.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- Defined: when step_mode=1, each retire goes to a HOLD state instead of FETCH. HOLD proceeds to FETCH on the first tick where step has been seen high (step is latched between ticks). retired still counts at the retire. stage is all zero in HOLD.
- Undefined: step_mode and step are ignored; no HOLD state is synthesised.

Test Plan:
- TICK_DIV=1, MEM_LATENCY=3, mem_ready tied 1, path 1 -> FETCH, FWAIT x3, DECODE, DISPATCH, REGFILE, EXECUTE, REGWRITE, FETCH. reg_write high exactly 1 cycle; retired 0 -> 1.
- Load (path 2) with mem_ready held 0 for 5 extra ticks in MWAIT -> FSM stays in MWAIT; REGWRITE occurs 1 tick after mem_ready rises; mem_wen never asserted.
- Store (path 3) -> mem_wen=1, addr_sel=1 for the whole MEMORY/MWAIT window; no reg_write; next FETCH uses addr_sel=0.
- jal (path 6) -> REGWRITE then JUMP; the following FETCH has addr_sel=2; retired increments once, not twice.
- path_index=12 -> SINK, illegal=1, halted=1, stage=8'b1000_0000. State is unchanged after 100 ticks; reset low returns all outputs to 0.
- TICK_DIV=4 with top_en dropped for 10 cycles in FWAIT -> state advances only on every 4th clk; the wait count resumes where it froze.
